// File: rtl/tva_pkg.sv
// Shared fixed-point helpers for the vision-transformer datapath blocks.
// Pure functions: zero latency, no state, no flow control.
package tva_pkg;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } fxp_rs_t;

  // Round half up, arithmetic shift by frac_bits, clamp to a signed data_width value.
  function automatic fxp_rs_t fxp_round_sat(input logic signed [127:0] acc,
                                            input int unsigned frac_bits,
                                            input int unsigned data_width);
    logic signed [127:0] r;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    fxp_rs_t res;
    r  = (acc + (128'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    hi = (128'sd1 <<< (data_width - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (data_width - 1));
    res.sat = 1'b0;
    res.val = r[63:0];
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi[63:0];
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo[63:0];
    end
    return res;
  endfunction

  // LSB position of element (row, col) in a row-major flattened bus.
  function automatic int unsigned flat_lsb(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols,
                                           input int unsigned width);
    return (row * cols + col) * width;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed MAC with bias preload: acc <= bias<<FRAC_BITS on load, acc += a*b on en.
// Latency 1 cycle per operation; no backpressure, caller sequences load/en.
module fxp_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_W      = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_vld,
  input  logic                         en_vld,
  input  logic signed [DATA_WIDTH-1:0] a_dat,
  input  logic signed [DATA_WIDTH-1:0] b_dat,
  input  logic signed [DATA_WIDTH-1:0] bias_dat,
  output logic signed [ACC_W-1:0]      acc_dat
);

  logic signed [ACC_W-1:0]        acc_q;
  logic signed [ACC_W-1:0]        acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a_dat * b_dat;

  always_comb begin
    acc_d = acc_q;
    if (load_vld) begin
      acc_d = ACC_W'(bias_dat) <<< FRAC_BITS;
    end else if (en_vld) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_dat = acc_q;

endmodule

// File: rtl/patch_embedding.sv
// Patch projection out = round_sat(patch * W + bias), one MAC per cycle, start/done handshake.
// Latency NUM_TOKENS*E*(PATCH_DIM+2)+1 cycles from start; no backpressure, inputs held stable.
module patch_embedding
  import tva_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_TOKENS = 196,
  parameter int PATCH_DIM  = 48,
  parameter int E          = 128
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  output logic                                     done,
  output logic                                     out_valid,
  input  logic [DATA_WIDTH*NUM_TOKENS*PATCH_DIM-1:0] patch_in,
  input  logic [DATA_WIDTH*PATCH_DIM*E-1:0]          W_in,
  input  logic [DATA_WIDTH*E-1:0]                    bias_in,
  output logic [DATA_WIDTH*NUM_TOKENS*E-1:0]         out_embed,
  output logic                                     sat_flag
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(PATCH_DIM) + 1;
  localparam int TW    = $clog2(NUM_TOKENS) + 1;
  localparam int EW    = $clog2(E) + 1;
  localparam int KW    = $clog2(PATCH_DIM) + 1;
  localparam int OUT_BITS = DATA_WIDTH*NUM_TOKENS*E;
  localparam int PIW   = $clog2(DATA_WIDTH*NUM_TOKENS*PATCH_DIM);
  localparam int WIW   = $clog2(DATA_WIDTH*PATCH_DIM*E);
  localparam int BIW   = $clog2(DATA_WIDTH*E);
  localparam int OIW   = $clog2(OUT_BITS);

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_INIT  = 3'd1;
  localparam state_t S_MAC   = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  state_t               state_q, state_d;
  logic [TW-1:0]        tok_q, tok_d;
  logic [EW-1:0]        e_q, e_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 sat_q, sat_d;
  logic                 done_q, done_d;
  logic [OUT_BITS-1:0]  out_mem_q, out_mem_d;
  logic [OUT_BITS-1:0]  out_embed_q, out_embed_d;

  logic [PIW-1:0] p_lsb;
  logic [WIW-1:0] w_lsb;
  logic [BIW-1:0] b_lsb;
  logic [OIW-1:0] o_lsb;

  logic signed [DATA_WIDTH-1:0] a_dat, b_dat, bias_dat;
  logic signed [ACC_W-1:0]      acc_dat;
  logic                         load_vld, en_vld;
  fxp_rs_t                      rs;

  assign p_lsb = PIW'(flat_lsb(32'(tok_q), 32'(k_q), PATCH_DIM, DATA_WIDTH));
  assign w_lsb = WIW'(flat_lsb(32'(k_q), 32'(e_q), E, DATA_WIDTH));
  assign b_lsb = BIW'(flat_lsb(0, 32'(e_q), E, DATA_WIDTH));
  assign o_lsb = OIW'(flat_lsb(32'(tok_q), 32'(e_q), E, DATA_WIDTH));

  assign a_dat    = patch_in[p_lsb +: DATA_WIDTH];
  assign b_dat    = W_in[w_lsb +: DATA_WIDTH];
  assign bias_dat = bias_in[b_lsb +: DATA_WIDTH];
  assign load_vld = (state_q == S_INIT);
  assign en_vld   = (state_q == S_MAC);
  assign rs       = fxp_round_sat(128'(acc_dat), FRAC_BITS, DATA_WIDTH);

  fxp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_vld (load_vld),
    .en_vld   (en_vld),
    .a_dat    (a_dat),
    .b_dat    (b_dat),
    .bias_dat (bias_dat),
    .acc_dat  (acc_dat)
  );

  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    e_d         = e_q;
    k_d         = k_q;
    sat_d       = sat_q;
    done_d      = 1'b0;
    out_mem_d   = out_mem_q;
    out_embed_d = out_embed_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tok_d   = '0;
          e_d     = '0;
          k_d     = '0;
          sat_d   = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(PATCH_DIM - 1)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        out_mem_d[o_lsb +: DATA_WIDTH] = rs.val[DATA_WIDTH-1:0];
        if (rs.sat) begin
          sat_d = 1'b1;
        end
        state_d = S_INIT;
        if (e_q == EW'(E - 1)) begin
          e_d = '0;
          if (tok_q == TW'(NUM_TOKENS - 1)) begin
            state_d = S_DONE;
          end else begin
            tok_d = tok_q + TW'(1);
          end
        end else begin
          e_d = e_q + EW'(1);
        end
      end
      S_DONE: begin
        out_embed_d = out_mem_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tok_q       <= '0;
      e_q         <= '0;
      k_q         <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      out_mem_q   <= '0;
      out_embed_q <= '0;
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      e_q         <= e_d;
      k_q         <= k_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      out_mem_q   <= out_mem_d;
      out_embed_q <= out_embed_d;
    end
  end

  assign done      = done_q;
  assign out_valid = done_q;
  assign sat_flag  = sat_q;
  assign out_embed = out_embed_q;

endmodule

// File: doc/patch_embedding.md
# patch_embedding

Time-multiplexed linear patch projection for the vision-transformer front end: flattened image patches (NUM_TOKENS × PATCH_DIM) are multiplied by a learned weight matrix (PATCH_DIM × E) and added to a learned bias (E), producing token embeddings (NUM_TOKENS × E). The output bus feeds `positional_encoding.A_in` directly and uses the same flattened layout, element (r, c) at bits [((r*COLS + c + 1)*DATA_WIDTH) - 1 -: DATA_WIDTH]. One signed fixed-point MAC per cycle, start/done control.

## Interface
- DATA_WIDTH, 16: element width, signed two's complement.
- FRAC_BITS, 8: fractional bits of all operands and the result (Q(DW-FB).FB); must be ≥ 1.
- NUM_TOKENS, 196: number of patches/tokens.
- PATCH_DIM, 48: elements per flattened patch (P*P*C).
- E, 128: embedding dimension.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in S_IDLE.
- done  out  1  one-cycle pulse when out_embed is updated.
- out_valid  out  1  identical to done; kept for interface symmetry with positional_encoding.
- patch_in  in  DATA_WIDTH*NUM_TOKENS*PATCH_DIM  patches, row-major [token][k].
- W_in  in  DATA_WIDTH*PATCH_DIM*E  weights, row-major [k][e].
- bias_in  in  DATA_WIDTH*E  bias [e].
- out_embed  out  DATA_WIDTH*NUM_TOKENS*E  embeddings, row-major [token][e].
- sat_flag  out  1  sticky; set if any output element saturated in the current run.

## Operation
- States: S_IDLE, S_INIT, S_MAC, S_WRITE, S_DONE.
- S_IDLE: start=1 → S_INIT; clear token_idx, dim_e, k_idx and sat_flag. start in any other state is ignored.
- S_INIT: acc ← sign_extend(bias[dim_e]) << FRAC_BITS; k_idx ← 0; → S_MAC.
- S_MAC: acc ← acc + patch[token_idx][k_idx] * W[k_idx][dim_e] (full 2*DW signed product); k_idx++; after k_idx == PATCH_DIM-1 → S_WRITE.
- S_WRITE: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift); clamp r to [-2^(DW-1), 2^(DW-1)-1]; set sat_flag on clamp; out_mem[token_idx][dim_e] ← r.
- Index advance in S_WRITE: dim_e increments, wrapping to 0 and incrementing token_idx. After (NUM_TOKENS-1, E-1) → S_DONE, else → S_INIT.
- S_DONE: copy out_mem to out_embed in one cycle; done, out_valid ← 1; → S_IDLE.
- Accumulator width ACC_W = 2*DATA_WIDTH + $clog2(PATCH_DIM) + 1. Accumulator never wraps.
- Inputs must be held stable from start until done; they are sampled throughout the run.
- out_embed changes only in S_DONE and holds its value between runs.
- sat_flag holds until the next accepted start.

## Timing
- Reset (async assert, any state): state = S_IDLE, done = out_valid = sat_flag = 0, out_embed = 0, out_mem = 0, all counters 0. A run in progress is abandoned with no done pulse.
- Per output element: PATCH_DIM + 2 cycles (INIT, MAC×PATCH_DIM, WRITE).
- Start sampled at edge 0 → done/out_valid/out_embed visible after edge N = NUM_TOKENS*E*(PATCH_DIM+2) + 1. Pulses are exactly 1 cycle.
- done is high while the FSM is already in S_IDLE. start asserted in that same cycle is accepted (back-to-back runs); the next done comes N edges later.
- PATCH_DIM = 1, E = 1 and NUM_TOKENS = 1 are all legal. Counters are sized $clog2(X)+1 bits.

## Structure
- Shared package tva_pkg: function fxp_round_sat(acc, FRAC_BITS, DATA_WIDTH) returning value and saturation bit; flat-bus index helper. positional_encoding and later stages reuse both.
- state_t typedef local to the module.
- One natural sub-module: fxp_mac (signed multiply-accumulate, clear/load-bias input, ACC_W parameter), reusable by later attention/MLP stages.

## Test plan
Bench parameters: NUM_TOKENS=2, PATCH_DIM=3, E=2, DW=16, FB=8 (1.0 = 0x0100); N = 21.
- patch all 0x0100, W all 0x0100, bias 0 → all four outputs 0x0300; done and out_valid high for exactly the one cycle after edge 21; sat_flag 0.
- patch 0xFF00 (−1.0), W 0x0200, bias 0x0080 → all outputs 0xFA80 (−5.5).
- Saturation: patch/W/bias all 0x7FFF → outputs 0x7FFF, sat_flag 1. Then a run with patch 0x8000, W 0x7FFF, bias 0 → outputs 0x8000, sat_flag 1. Then a run with clean data → sat_flag cleared at start.
- Rounding: patch 0x0001, W 0x0080, bias 0 → accumulator 384 → output 0x0002. W 0x0040, bias 0 → accumulator 192 → output 0x0001.
- Control:
  - start pulsed mid-run is ignored (done still at edge 21).
  - rst_n low at edge 10 → outputs 0, no done pulse; new start → done 21 edges later.
  - start held during the done cycle → second done 21 edges later.
- Distinct per-element patch and W values (random, seeded) → out_embed matches a reference model bit-exactly, including flat-bus ordering.
